aes_block_sequencer: RTL and testbench
======================================

Name: aes_block_sequencer

Overview:
Autonomous command sequencer between the Wishbone-side buffering and the `aes` core register port.
- Accepts a key command and plaintext/ciphertext blocks on valid/ready streams.
- Drives the core's cs/we/address/write_data bus to load config and key, trigger init/next, poll status and read the result.
- Returns 128-bit results on a valid/ready stream.
- Removes per-word register poking from firmware; one instance per `aes` core.

Parameters:
- SETTLE_CYCLES, 2: idle cycles after a CTRL write before the first STATUS poll.
- POLL_TIMEOUT, 1024: max STATUS polls before error; used only with AES_SEQ_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous active-high reset.
- key_valid  in  1  key command offered.
- key_ready  out  1  key command accepted when key_valid && key_ready.
- key_data  in  256  key; MSW in [255:224]; a 128-bit key sits in [255:128].
- key_len  in  1  0 = AES-128, 1 = AES-256.
- enc_dec  in  1  1 = encrypt, 0 = decrypt; applies to all blocks until the next key command.
- blk_valid  in  1  input block offered.
- blk_ready  out  1  block accepted on handshake.
- blk_data  in  128  block; MSW in [127:96].
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  128  result; MSW in [127:96].
- busy  out  1  high in any state other than IDLE.
- key_loaded  out  1  a key expansion has completed since reset.
- aes_cs  out  1  core chip select.
- aes_we  out  1  core write enable.
- aes_address  out  8  core register address.
- aes_write_data  out  32  core write data.
- aes_read_data  in  32  core read data; combinational, valid in the same cycle as cs && !we.

Behaviour:
- Clock and reset: one clock (wb_clk_i). Reset is synchronous, active-high (wb_rst_i).
- Reset values: all outputs 0, except res_data, which holds its last value (don't-care). State = IDLE.
- Reset mid-operation: aborts the sequence and clears key_loaded. The core is reset by the same wb_rst_i.
- Core address map:
  - CTRL 0x08: bit0 init, bit1 next.
  - STATUS 0x09: bit0 ready, bit1 valid.
  - CONFIG 0x0A: bit0 encdec, bit1 keylen.
  - KEY0-7 0x10-0x17.
  - BLOCK0-3 0x20-0x23.
  - RESULT0-3 0x30-0x33.
  - Word 0 is always the MSW.
- Core bus timing: exactly one core access per cycle. aes_cs is 0 in idle and settle cycles. aes_we = 1 only in write states.
- FSM states: IDLE, CFG_WR, KEY_WR, INIT_WR, BLK_WR, NEXT_WR, SETTLE, POLL, RES_RD, RES_OUT.
- IDLE:
  - key_ready = 1.
  - blk_ready = key_loaded && !key_valid, so a key command has priority when both are offered.
  - On key handshake: capture key_data, key_len and enc_dec, then go to CFG_WR.
  - On block handshake: capture blk_data, then go to BLK_WR.
- CFG_WR: 1 cycle, then KEY_WR.
- KEY_WR: 8 cycles writing KEY0..KEY7 (all 8 words regardless of key_len), then INIT_WR.
- INIT_WR: writes CTRL = 0x1, then SETTLE.
- BLK_WR: 4 cycles writing BLOCK0..3, then NEXT_WR.
- NEXT_WR: writes CTRL = 0x2, then SETTLE.
- SETTLE: SETTLE_CYCLES idle cycles, then POLL.
- POLL: reads STATUS every cycle until bit0 = 1.
  - Key path: set key_loaded, go to IDLE.
  - Block path: go to RES_RD.
- RES_RD: 4 cycles reading RESULT0..3 into res_data, then RES_OUT.
- RES_OUT:
  - res_valid = 1 and res_data stays stable until res_ready.
  - The handshake cycle returns to IDLE, and res_valid drops in the next cycle.
  - No new command is accepted while the result is pending.
- Minimum latency, block handshake to res_valid: 4 + 1 + SETTLE_CYCLES + polls + 4 cycles.
- A new key command leaves key_loaded set and reloads config and key. Blocks are accepted afterwards only once the new expansion completes, because the FSM is non-IDLE until then.

Optional Feature:
- Macro: AES_SEQ_TIMEOUT_EN.
- With it defined:
  - A poll counter of width clog2(POLL_TIMEOUT+1) counts STATUS reads.
  - When it reaches POLL_TIMEOUT, the FSM goes to IDLE and sets the sticky output `seq_err` (1 bit).
  - seq_err is cleared only by reset or by an accepted key command.
  - For a block-path timeout, no result is produced.
  - After a key-path timeout, key_loaded = 0.
- Without it: POLL waits indefinitely; the seq_err port does not exist.

Decomposition:
- Package aes_seq_pkg:
  - core address constants (ADDR_CTRL, ADDR_STATUS, ADDR_CONFIG, ADDR_KEY0, ADDR_BLOCK0, ADDR_RESULT0);
  - CTRL/STATUS bit indices;
  - the FSM state enum.
- The word index counter and word-select mux stay inline.
- One natural sub-module: aes_seq_poll (settle counter, STATUS polling, optional timeout), returning done/timeout to the main FSM.

Test Plan:
- AES-128 encrypt: key_data[255:128] = 000102030405060708090a0b0c0d0e0f, enc_dec = 1, then block 00112233445566778899aabbccddeeff -> res_data 69c4e0d86a7b0430d8cdb78070b4c55a. The bus trace shows CONFIG = 0x1, 8 key writes, CTRL = 0x1, then 4 block writes and CTRL = 0x2.
- AES-256 decrypt: key 000102...1f, key_len = 1, enc_dec = 0, block 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff.
- Before any key: blk_valid = 1 -> blk_ready stays 0 and aes_cs stays 0 for 50 cycles.
- Backpressure: hold res_ready = 0 for 20 cycles -> res_valid and res_data stay stable and blk_ready = 0. Release -> exactly one transfer.
- Simultaneous key_valid and blk_valid in IDLE with key_loaded = 1 -> key accepted first, then the block is processed under the new key.
- Reset asserted during POLL -> next cycle all outputs 0, key_loaded = 0, FSM in IDLE. With AES_SEQ_TIMEOUT_EN and POLL_TIMEOUT = 8 and a core model whose ready is stuck at 0 -> seq_err = 1 after 8 polls.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - core register map, bit indices and sequencer states for aes_block_sequencer
package aes_seq_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
  localparam logic [7:0] ADDR_KEY0    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
  localparam logic [7:0] ADDR_RESULT0 = 8'h30;

  localparam int CTRL_INIT_BIT     = 0;
  localparam int CTRL_NEXT_BIT     = 1;
  localparam int STATUS_READY_BIT  = 0;
  localparam int STATUS_VALID_BIT  = 1;
  localparam int CONFIG_ENCDEC_BIT = 0;
  localparam int CONFIG_KEYLEN_BIT = 1;

  typedef enum logic [3:0] {
    IDLE,
    CFG_WR,
    KEY_WR,
    INIT_WR,
    BLK_WR,
    NEXT_WR,
    SETTLE,
    POLL,
    RES_RD,
    RES_OUT
  } seq_state_t;

endpackage

// File: rtl/aes_seq_poll.sv
// rtl/aes_seq_poll.sv - settle delay and STATUS ready polling; AES_SEQ_TIMEOUT_EN adds a poll limit
module aes_seq_poll #(
  parameter int SETTLE_CYCLES = 2
`ifdef AES_SEQ_TIMEOUT_EN
  , parameter int POLL_TIMEOUT = 1024
`endif
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic settling,
  input  logic polling,
  input  logic status_ready,
  output logic settle_done,
  output logic poll_done,
  output logic poll_timeout
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [SW-1:0] settle_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !settling) settle_cnt <= '0;
    else                       settle_cnt <= settle_cnt + 1'b1;
  end

  assign settle_done = settling && (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign poll_done   = polling && status_ready;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  // counts unanswered STATUS reads of the current poll phase
  logic [PW-1:0] poll_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !polling) poll_cnt <= '0;
    else                      poll_cnt <= poll_cnt + 1'b1;
  end

  assign poll_timeout = polling && !status_ready && (poll_cnt == PW'(POLL_TIMEOUT - 1));
`else
  assign poll_timeout = 1'b0;
`endif

endmodule

// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - drives the aes core register port from key/block streams to a result stream
// Optional poll timeout and seq_err output under AES_SEQ_TIMEOUT_EN.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
`ifdef AES_SEQ_TIMEOUT_EN
  , parameter int POLL_TIMEOUT = 1024
`endif
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_data,
  input  logic         key_len,
  input  logic         enc_dec,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         busy,
  output logic         key_loaded,
`ifdef AES_SEQ_TIMEOUT_EN
  output logic         seq_err,
`endif
  output logic         aes_cs,
  output logic         aes_we,
  output logic [7:0]   aes_address,
  output logic [31:0]  aes_write_data,
  input  logic [31:0]  aes_read_data
);

  seq_state_t    state, state_next;
  logic [2:0]    word_idx;
  logic [255:0]  key_sh;
  logic [127:0]  blk_sh;
  logic          key_len_r, enc_dec_r, key_path;
  logic          settle_done, poll_done, poll_timeout;

  aes_seq_poll #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
`ifdef AES_SEQ_TIMEOUT_EN
    , .POLL_TIMEOUT(POLL_TIMEOUT)
`endif
  ) u_poll (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .settling    (state == SETTLE),
    .polling     (state == POLL),
    .status_ready(aes_read_data[STATUS_READY_BIT]),
    .settle_done (settle_done),
    .poll_done   (poll_done),
    .poll_timeout(poll_timeout)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next     = state;
    key_ready      = 1'b0;
    blk_ready      = 1'b0;
    res_valid      = 1'b0;
    aes_cs         = 1'b0;
    aes_we         = 1'b0;
    aes_address    = 8'h00;
    aes_write_data = 32'h0;
    case (state)
      IDLE: begin
        // a pending key command wins over a block offered in the same cycle
        key_ready = !wb_rst_i;
        blk_ready = !wb_rst_i && key_loaded && !key_valid;
        if (key_valid)                   state_next = CFG_WR;
        else if (blk_valid && blk_ready) state_next = BLK_WR;
      end
      CFG_WR: begin
        aes_cs = 1'b1;
        aes_we = 1'b1;
        aes_address = ADDR_CONFIG;
        aes_write_data[CONFIG_ENCDEC_BIT] = enc_dec_r;
        aes_write_data[CONFIG_KEYLEN_BIT] = key_len_r;
        state_next = KEY_WR;
      end
      KEY_WR: begin
        aes_cs = 1'b1;
        aes_we = 1'b1;
        aes_address = ADDR_KEY0 + {5'b0, word_idx};
        aes_write_data = key_sh[255:224];
        if (word_idx == 3'd7) state_next = INIT_WR;
      end
      INIT_WR: begin
        aes_cs = 1'b1;
        aes_we = 1'b1;
        aes_address = ADDR_CTRL;
        aes_write_data[CTRL_INIT_BIT] = 1'b1;
        state_next = SETTLE;
      end
      BLK_WR: begin
        aes_cs = 1'b1;
        aes_we = 1'b1;
        aes_address = ADDR_BLOCK0 + {6'b0, word_idx[1:0]};
        aes_write_data = blk_sh[127:96];
        if (word_idx[1:0] == 2'd3) state_next = NEXT_WR;
      end
      NEXT_WR: begin
        aes_cs = 1'b1;
        aes_we = 1'b1;
        aes_address = ADDR_CTRL;
        aes_write_data[CTRL_NEXT_BIT] = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_done) state_next = POLL;
      end
      POLL: begin
        aes_cs = 1'b1;
        aes_address = ADDR_STATUS;
        if (poll_done)         state_next = key_path ? IDLE : RES_RD;
        else if (poll_timeout) state_next = IDLE;
      end
      RES_RD: begin
        aes_cs = 1'b1;
        aes_address = ADDR_RESULT0 + {6'b0, word_idx[1:0]};
        if (word_idx[1:0] == 2'd3) state_next = RES_OUT;
      end
      RES_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) word_idx <= '0;
    else if (state == KEY_WR || state == BLK_WR || state == RES_RD) word_idx <= word_idx + 1'b1;
    else word_idx <= '0;
  end

  // key and block registers shift out MSW first so the write data is always the top word
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      key_sh     <= '0;
      blk_sh     <= '0;
      key_len_r  <= 1'b0;
      enc_dec_r  <= 1'b0;
      key_path   <= 1'b0;
      key_loaded <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      seq_err    <= 1'b0;
`endif
    end else begin
      if (state == IDLE && key_valid) begin
        key_sh    <= key_data;
        key_len_r <= key_len;
        enc_dec_r <= enc_dec;
        key_path  <= 1'b1;
`ifdef AES_SEQ_TIMEOUT_EN
        seq_err   <= 1'b0;
`endif
      end else if (state == IDLE && blk_valid && blk_ready) begin
        blk_sh   <= blk_data;
        key_path <= 1'b0;
      end
      if (state == KEY_WR) key_sh <= {key_sh[223:0], 32'h0};
      if (state == BLK_WR) blk_sh <= {blk_sh[95:0], 32'h0};
      if (state == POLL && poll_done && key_path) key_loaded <= 1'b1;
`ifdef AES_SEQ_TIMEOUT_EN
      if (state == POLL && poll_timeout) begin
        seq_err <= 1'b1;
        if (key_path) key_loaded <= 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (state == RES_RD) res_data <= {res_data[95:0], aes_read_data};
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb/tb_aes_block_sequencer.sv - self-checking bench for aes_block_sequencer with a behavioural aes core
module tb_aes_block_sequencer;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         key_valid = 1'b0, key_len = 1'b0, enc_dec = 1'b0;
  logic [255:0] key_data = '0;
  logic         blk_valid = 1'b0, res_ready = 1'b0;
  logic [127:0] blk_data = '0;
  logic         key_ready, blk_ready, res_valid, busy, key_loaded;
  logic [127:0] res_data;
  logic         aes_cs, aes_we;
  logic [7:0]   aes_address;
  logic [31:0]  aes_write_data, aes_read_data;
`ifdef AES_SEQ_TIMEOUT_EN
  logic         seq_err;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int status_reads = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  aes_block_sequencer #(
    .SETTLE_CYCLES(2)
`ifdef AES_SEQ_TIMEOUT_EN
    , .POLL_TIMEOUT(8)
`endif
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .key_len(key_len), .enc_dec(enc_dec),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .key_loaded(key_loaded),
`ifdef AES_SEQ_TIMEOUT_EN
    .seq_err(seq_err),
`endif
    .aes_cs(aes_cs), .aes_we(aes_we), .aes_address(aes_address),
    .aes_write_data(aes_write_data), .aes_read_data(aes_read_data)
  );

  localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // Reference transform: the published vectors, otherwise an arbitrary keyed scramble
  function automatic logic [127:0] ref_xform(input logic klen, input logic enc,
                                             input logic [255:0] k, input logic [127:0] b);
    logic [127:0] x;
    if (!klen && enc && k[255:128] == KEY1[255:128] && b == PT1) return CT1;
    if (klen && !enc && k == KEY2 && b == CT2) return PT1;
    x = b ^ k[255:128] ^ {k[120:0], k[127:121]} ^ {126'b0, klen, enc};
    return enc ? x : ~x;
  endfunction

  logic [1:0]   core_cfg;
  logic [31:0]  core_key [8];
  logic [31:0]  core_blk [4];
  logic         core_ready;
  logic [127:0] core_res;
  int           core_busy;
  bit           stuck = 1'b0;
  logic [39:0]  wr_q [$];

  always @(posedge wb_clk_i) begin
    cyc++;
    if (wb_rst_i) begin
      core_ready <= 1'b1;
      core_busy  <= 0;
    end else begin
      if (aes_cs && !aes_we && aes_address == 8'h09) status_reads++;
      if (aes_cs && aes_we) begin
        wr_q.push_back({aes_address, aes_write_data});
        if (aes_address == 8'h0a) core_cfg <= aes_write_data[1:0];
        else if (aes_address[7:3] == 5'b00010) core_key[aes_address[2:0]] <= aes_write_data;
        else if (aes_address[7:2] == 6'b001000) core_blk[aes_address[1:0]] <= aes_write_data;
        else if (aes_address == 8'h08 && aes_write_data[1:0] != 2'b00) begin
          core_ready <= 1'b0;
          core_busy  <= $urandom_range(1, 6);
          if (aes_write_data[1])
            core_res <= ref_xform(core_cfg[1], core_cfg[0],
                                  {core_key[0], core_key[1], core_key[2], core_key[3],
                                   core_key[4], core_key[5], core_key[6], core_key[7]},
                                  {core_blk[0], core_blk[1], core_blk[2], core_blk[3]});
        end
      end else if (core_busy > 0) begin
        core_busy <= core_busy - 1;
        if (core_busy == 1 && !stuck) core_ready <= 1'b1;
      end
    end
  end

  always @* begin
    aes_read_data = 32'h0;
    if (aes_cs && !aes_we)
      case (aes_address)
        8'h09:   aes_read_data = {30'b0, core_ready, core_ready};
        8'h30:   aes_read_data = core_res[127:96];
        8'h31:   aes_read_data = core_res[95:64];
        8'h32:   aes_read_data = core_res[63:32];
        8'h33:   aes_read_data = core_res[31:0];
        default: aes_read_data = 32'h0;
      endcase
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_key(input logic [255:0] k, input logic l, input logic e);
    int n = 0;
    @(negedge wb_clk_i);
    key_data = k; key_len = l; enc_dec = e; key_valid = 1'b1;
    while (!key_ready && n < 500) begin @(negedge wb_clk_i); n++; end
    check("key_accept_bound", n < 500, 1'b1);
    @(posedge wb_clk_i); #1;
    key_valid = 1'b0;
    status_reads = 0;
    n = 0;
    @(negedge wb_clk_i);
    while (busy && n < 3000) begin @(negedge wb_clk_i); n++; end
    check("key_load_bound", n < 3000, 1'b1);
  endtask

  // hold: cycles of res_ready backpressure before the result is taken
  task automatic send_block(input logic [127:0] b, input logic [127:0] exp, input int hold, input string tag);
    int n = 0;
    int t0, xfers;
    bit stable;
    @(negedge wb_clk_i);
    blk_data = b; blk_valid = 1'b1;
    while (!blk_ready && n < 3000) begin @(negedge wb_clk_i); n++; end
    check({tag, "_accept_bound"}, n < 3000, 1'b1);
    @(posedge wb_clk_i); #1;
    blk_valid = 1'b0;
    t0 = cyc;
    status_reads = 0;
    n = 0;
    @(negedge wb_clk_i);
    while (!res_valid && n < 3000) begin @(negedge wb_clk_i); n++; end
    check({tag, "_res_bound"}, n < 3000, 1'b1);
    check({tag, "_data"}, res_data, exp);
    check({tag, "_latency"}, cyc - t0, 11 + status_reads);
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge wb_clk_i);
        if (!(res_valid && res_data === exp && !blk_ready && !key_ready)) stable = 1'b0;
      end
      check({tag, "_backpressure_stable"}, stable, 1'b1);
    end
    res_ready = 1'b1;
    xfers = (res_valid && res_ready) ? 1 : 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (res_valid && res_ready) xfers++;
    end
    res_ready = 1'b0;
    check({tag, "_one_transfer"}, xfers, 1);
    check({tag, "_valid_drop"}, res_valid, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k, kb;
    logic [127:0] b;
    logic l, e;
    bit seen;
    int n;

    repeat (3) @(negedge wb_clk_i);
    check("rst_outputs", {key_ready, blk_ready, res_valid, busy, key_loaded, aes_cs, aes_we}, 7'b0);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("idle_key_ready", key_ready, 1'b1);
    check("idle_blk_ready_nokey", blk_ready, 1'b0);

    blk_valid = 1'b1; blk_data = PT1; seen = 1'b0;
    repeat (50) begin
      @(negedge wb_clk_i);
      if (blk_ready || aes_cs) seen = 1'b1;
    end
    blk_valid = 1'b0;
    check("nokey_block_ignored", seen, 1'b0);

    wr_q.delete();
    send_key(KEY1, 1'b0, 1'b1);
    check("aes128_key_loaded", key_loaded, 1'b1);
    check("aes128_key_trace_len", wr_q.size(), 10);
    if (wr_q.size() == 10) begin
      check("trace_config", wr_q[0], {8'h0a, 32'h1});
      for (int i = 0; i < 8; i++)
        check($sformatf("trace_key%0d", i), wr_q[1+i], {8'(8'h10 + i), KEY1[255 - 32*i -: 32]});
      check("trace_init", wr_q[9], {8'h08, 32'h1});
    end
    wr_q.delete();
    send_block(PT1, CT1, 0, "aes128_enc");
    check("aes128_blk_trace_len", wr_q.size(), 5);
    if (wr_q.size() == 5) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("trace_blk%0d", i), wr_q[i], {8'(8'h20 + i), PT1[127 - 32*i -: 32]});
      check("trace_next", wr_q[4], {8'h08, 32'h2});
    end

    send_key(KEY2, 1'b1, 1'b0);
    send_block(CT2, PT1, 0, "aes256_dec");

    for (int it = 0; it < 4; it++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      l = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      send_key(k, l, e);
      for (int j = 0; j < 3; j++) begin
        b = {$urandom, $urandom, $urandom, $urandom};
        send_block(b, ref_xform(l, e, k, b), 0, $sformatf("rand_%0d_%0d", it, j));
      end
    end

    b = {$urandom, $urandom, $urandom, $urandom};
    send_block(b, ref_xform(l, e, k, b), 20, "backpressure");

    kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    @(negedge wb_clk_i);
    key_data = kb; key_len = 1'b1; enc_dec = 1'b1; key_valid = 1'b1;
    blk_data = b; blk_valid = 1'b1;
    #1;
    check("simul_key_ready", key_ready, 1'b1);
    check("simul_blk_ready", blk_ready, 1'b0);
    @(posedge wb_clk_i); #1;
    key_valid = 1'b0;
    check("simul_key_taken", busy, 1'b1);
    send_block(b, ref_xform(1'b1, 1'b1, kb, b), 0, "simul_new_key");

    stuck = 1'b1;
    @(negedge wb_clk_i);
    blk_data = b; blk_valid = 1'b1;
    n = 0;
    while (!blk_ready && n < 100) begin @(negedge wb_clk_i); n++; end
    @(posedge wb_clk_i); #1;
    blk_valid = 1'b0;
    n = 0;
    while (!(aes_cs && !aes_we && aes_address == 8'h09) && n < 100) begin @(negedge wb_clk_i); n++; end
    check("poll_reached", n < 100, 1'b1);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("midrst_ctrl", {key_ready, blk_ready, res_valid, busy, key_loaded, aes_cs, aes_we}, 7'b0);
    check("midrst_bus", {aes_address, aes_write_data}, 40'h0);
`ifdef AES_SEQ_TIMEOUT_EN
    check("midrst_seq_err", seq_err, 1'b0);
`endif
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0; stuck = 1'b0;
    @(negedge wb_clk_i);
    check("postrst_idle", {key_ready, busy, key_loaded}, 3'b100);

`ifdef AES_SEQ_TIMEOUT_EN
    send_key(KEY1, 1'b0, 1'b1);
    stuck = 1'b1;
    @(negedge wb_clk_i);
    blk_data = PT1; blk_valid = 1'b1;
    @(posedge wb_clk_i); #1;
    blk_valid = 1'b0;
    status_reads = 0; seen = 1'b0; n = 0;
    @(negedge wb_clk_i);
    while (busy && n < 200) begin
      if (res_valid) seen = 1'b1;
      @(negedge wb_clk_i); n++;
    end
    check("blk_timeout_polls", status_reads, 8);
    check("blk_timeout_err", seq_err, 1'b1);
    check("blk_timeout_no_result", seen, 1'b0);
    check("blk_timeout_key_kept", key_loaded, 1'b1);
    stuck = 1'b0;
    send_key(KEY1, 1'b0, 1'b1);
    check("err_cleared_by_key", seq_err, 1'b0);
    stuck = 1'b1;
    send_key(KEY2, 1'b1, 1'b0);
    check("key_timeout_polls", status_reads, 8);
    check("key_timeout_err", seq_err, 1'b1);
    check("key_timeout_unloaded", key_loaded, 1'b0);
    stuck = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
